// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one single-beat Wishbone slave port between NM masters.
// The grant is held for the whole master cycle; a response watchdog aborts hung cycles.
module wb_rr_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int NM      = 2,
    parameter int TMO_CYC = 255
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    output logic [DW-1:0]        m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [NM-1:0]        m_rty_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    output logic [2:0]           s_cti_o,
    output logic [1:0]           s_bte_o,
    input  logic [DW-1:0]        s_dat_i,
    input  logic                 s_ack_i,
    input  logic                 s_err_i,
    input  logic                 s_rty_i,
    output logic [NM-1:0]        grant_o,
    output logic                 busy_o
);

    localparam int SW = DW / 8;
    localparam int LW = $clog2(NM);
    // Keep the watchdog counter at least one bit wide even when it is disabled.
    localparam int CW = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ABORT = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [NM-1:0]   grant_reg, grant_next;
    logic [LW-1:0]   gidx_reg, gidx_next;
    logic [LW-1:0]   last_reg, last_next;
    logic [CW-1:0]   wd_reg, wd_next;
    logic            abort_first_reg, abort_first_next;

    logic [LW-1:0]   win_idx;
    logic            win_found;
    logic            g_cyc;
    logic            g_stb;
    logic            resp;
    logic            wd_expired;
    logic            in_grant;
    logic            in_abort;

    assign g_cyc      = m_cyc_i[gidx_reg];
    assign g_stb      = m_stb_i[gidx_reg];
    assign resp       = s_ack_i | s_err_i | s_rty_i;
    assign wd_expired = (TMO_CYC != 0) && (wd_reg == CW'(TMO_CYC));
    assign in_grant   = (state_reg == ST_GRANT);
    assign in_abort   = (state_reg == ST_ABORT);

    // Rotating priority: scan last+1, last+2, ... and take the first requester.
    always_comb begin
        int p;
        p         = 0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NM; k++) begin
            p = (int'(last_reg) + k) % NM;
            if (!win_found && m_cyc_i[p]) begin
                win_found = 1'b1;
                win_idx   = LW'(p);
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_reg       <= ST_IDLE;
            grant_reg       <= '0;
            gidx_reg        <= '0;
            last_reg        <= LW'(NM - 1);
            wd_reg          <= '0;
            abort_first_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            grant_reg       <= grant_next;
            gidx_reg        <= gidx_next;
            last_reg        <= last_next;
            wd_reg          <= wd_next;
            abort_first_reg <= abort_first_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        grant_next       = grant_reg;
        gidx_next        = gidx_reg;
        last_next        = last_reg;
        wd_next          = wd_reg;
        abort_first_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                wd_next = '0;
                if (win_found) begin
                    state_next = ST_GRANT;
                    gidx_next  = win_idx;
                    last_next  = win_idx;
                    grant_next = NM'(1) << win_idx;
                end
            end
            ST_GRANT: begin
                if (!g_cyc) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                    wd_next    = '0;
                end else if (resp || !g_stb) begin
                    // A response arriving with expiry still wins.
                    wd_next = '0;
                end else if (wd_expired) begin
                    state_next       = ST_ABORT;
                    abort_first_next = 1'b1;
                end else if (TMO_CYC != 0) begin
                    wd_next = wd_reg + CW'(1);
                end
            end
            ST_ABORT: begin
                wd_next = '0;
                if (!g_cyc) begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                grant_next = '0;
                wd_next    = '0;
            end
        endcase
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        if (in_grant) begin
            s_adr_o = m_adr_i[gidx_reg*AW +: AW];
            s_dat_o = m_dat_i[gidx_reg*DW +: DW];
            s_sel_o = m_sel_i[gidx_reg*SW +: SW];
            s_we_o  = m_we_i[gidx_reg];
            s_cyc_o = g_cyc;
            s_stb_o = g_stb;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NM; gi++) begin : g_resp
            assign m_ack_o[gi] = grant_reg[gi] & in_grant & s_ack_i;
            assign m_rty_o[gi] = grant_reg[gi] & in_grant & s_rty_i;
            // The abort error is a single pulse; later slave responses are dropped.
            assign m_err_o[gi] = grant_reg[gi] &
                                 ((in_grant & s_err_i) | (in_abort & abort_first_reg));
        end
    endgenerate

    assign m_dat_o = s_dat_i;
    assign s_cti_o = 3'b000;
    assign s_bte_o = 2'b00;
    assign grant_o = grant_reg;
    assign busy_o  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: vector table, directed corner sequences
// and randomized traffic compared against a cycle-level behavioural model.
module tb_wb_rr_arbiter;

    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int NM  = 2;
    localparam int TMO = 16;
    localparam int SW  = DW / 8;

    logic              clk;
    logic              rst_n;
    logic [NM*AW-1:0]  m_adr;
    logic [NM*DW-1:0]  m_dat;
    logic [NM*SW-1:0]  m_sel;
    logic [NM-1:0]     m_we;
    logic [NM-1:0]     m_cyc;
    logic [NM-1:0]     m_stb;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack_o;
    logic [NM-1:0]     m_err_o;
    logic [NM-1:0]     m_rty_o;
    logic [AW-1:0]     s_adr_o;
    logic [DW-1:0]     s_dat_o;
    logic [SW-1:0]     s_sel_o;
    logic              s_we_o;
    logic              s_cyc_o;
    logic              s_stb_o;
    logic [2:0]        s_cti_o;
    logic [1:0]        s_bte_o;
    logic [DW-1:0]     s_dat;
    logic              s_ack;
    logic              s_err;
    logic              s_rty;
    logic [NM-1:0]     grant_o;
    logic              busy_o;

    int n_assert = 0;
    int n_fail   = 0;

    wb_rr_arbiter #(.DW(DW), .AW(AW), .NM(NM), .TMO_CYC(TMO)) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .m_adr_i  (m_adr),
        .m_dat_i  (m_dat),
        .m_sel_i  (m_sel),
        .m_we_i   (m_we),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .m_rty_o  (m_rty_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_cti_o  (s_cti_o),
        .s_bte_o  (s_bte_o),
        .s_dat_i  (s_dat),
        .s_ack_i  (s_ack),
        .s_err_i  (s_err),
        .s_rty_i  (s_rty),
        .grant_o  (grant_o),
        .busy_o   (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, got running required finished");
        $fatal(1, "timeout");
    end

    // Behavioural model: who owns the port, whether it was aborted, and how long
    // the slave has been silent on the current strobe.
    int mdl_owner;
    int mdl_last;
    int mdl_silent;
    bit mdl_abort;
    bit mdl_first_abort;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
        s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        next_cyc();
        next_cyc();
        rst_n = 1'b1;
        mdl_owner = -1; mdl_last = NM - 1; mdl_silent = 0;
        mdl_abort = 1'b0; mdl_first_abort = 1'b0;
    endtask

    task automatic model_check(input int cycle);
        logic [NM-1:0] e_grant, e_ack, e_err, e_rty;
        logic          e_cyc, e_stb, e_we, e_busy;
        logic [AW-1:0] e_adr;
        logic [DW-1:0] e_dat;
        logic [SW-1:0] e_sel;
        e_grant = '0; e_ack = '0; e_err = '0; e_rty = '0;
        e_cyc = 0; e_stb = 0; e_we = 0; e_busy = 0;
        e_adr = '0; e_dat = '0; e_sel = '0;
        if (mdl_owner >= 0) begin
            e_grant[mdl_owner] = 1'b1;
            e_busy = 1'b1;
            if (!mdl_abort) begin
                e_cyc = m_cyc[mdl_owner];
                e_stb = m_stb[mdl_owner];
                e_we  = m_we[mdl_owner];
                e_adr = m_adr[mdl_owner*AW +: AW];
                e_dat = m_dat[mdl_owner*DW +: DW];
                e_sel = m_sel[mdl_owner*SW +: SW];
                e_ack[mdl_owner] = s_ack;
                e_err[mdl_owner] = s_err;
                e_rty[mdl_owner] = s_rty;
            end else begin
                e_err[mdl_owner] = mdl_first_abort;
            end
        end
        chk($sformatf("rnd%0d_grant", cycle), 64'(grant_o), 64'(e_grant));
        chk($sformatf("rnd%0d_busy", cycle), 64'(busy_o), 64'(e_busy));
        chk($sformatf("rnd%0d_s_cyc", cycle), 64'(s_cyc_o), 64'(e_cyc));
        chk($sformatf("rnd%0d_s_stb", cycle), 64'(s_stb_o), 64'(e_stb));
        chk($sformatf("rnd%0d_s_we", cycle), 64'(s_we_o), 64'(e_we));
        chk($sformatf("rnd%0d_s_adr", cycle), 64'(s_adr_o), 64'(e_adr));
        chk($sformatf("rnd%0d_s_dat", cycle), 64'(s_dat_o), 64'(e_dat));
        chk($sformatf("rnd%0d_s_sel", cycle), 64'(s_sel_o), 64'(e_sel));
        chk($sformatf("rnd%0d_m_ack", cycle), 64'(m_ack_o), 64'(e_ack));
        chk($sformatf("rnd%0d_m_err", cycle), 64'(m_err_o), 64'(e_err));
        chk($sformatf("rnd%0d_m_rty", cycle), 64'(m_rty_o), 64'(e_rty));
        chk($sformatf("rnd%0d_m_dat", cycle), 64'(m_dat_o), 64'(s_dat));
    endtask

    task automatic model_clock();
        if (mdl_owner < 0) begin
            for (int k = 1; k <= NM; k++) begin
                if (mdl_owner < 0 && m_cyc[(mdl_last + k) % NM]) begin
                    mdl_owner = (mdl_last + k) % NM;
                end
            end
            if (mdl_owner >= 0) mdl_last = mdl_owner;
            mdl_silent = 0;
        end else if (mdl_abort) begin
            mdl_first_abort = 1'b0;
            if (!m_cyc[mdl_owner]) begin
                mdl_owner = -1;
                mdl_abort = 1'b0;
            end
        end else if (!m_cyc[mdl_owner]) begin
            mdl_owner = -1;
        end else if (s_ack || s_err || s_rty || !m_stb[mdl_owner]) begin
            mdl_silent = 0;
        end else if (mdl_silent >= TMO) begin
            mdl_abort = 1'b1;
            mdl_first_abort = 1'b1;
        end else begin
            mdl_silent++;
        end
    endtask

    typedef struct {
        logic [1:0] cyc;
        logic [1:0] stb;
        logic       ack;
        logic       err;
        logic       rty;
        logic [1:0] e_grant;
        logic       e_scyc;
        logic [1:0] e_ack;
        logic [1:0] e_err;
        logic [1:0] e_rty;
        logic       e_busy;
    } vec_t;

    vec_t vt[13];
    int   dead;

    initial begin
        // Row order matters: each row is one clock, starting right after reset.
        vt[0]  = '{2'b11, 2'b11, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0};
        vt[1]  = '{2'b11, 2'b11, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 2'b00, 1};
        vt[2]  = '{2'b11, 2'b11, 1, 0, 0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 1};
        vt[3]  = '{2'b10, 2'b10, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 1};
        vt[4]  = '{2'b10, 2'b10, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0};
        vt[5]  = '{2'b10, 2'b10, 0, 1, 0, 2'b10, 1, 2'b00, 2'b10, 2'b00, 1};
        vt[6]  = '{2'b10, 2'b10, 0, 0, 1, 2'b10, 1, 2'b00, 2'b00, 2'b10, 1};
        vt[7]  = '{2'b10, 2'b10, 1, 0, 0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 1};
        vt[8]  = '{2'b00, 2'b00, 0, 0, 0, 2'b10, 0, 2'b00, 2'b00, 2'b00, 1};
        vt[9]  = '{2'b11, 2'b11, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0};
        vt[10] = '{2'b11, 2'b11, 0, 0, 0, 2'b01, 1, 2'b00, 2'b00, 2'b00, 1};
        vt[11] = '{2'b00, 2'b00, 0, 0, 0, 2'b01, 0, 2'b00, 2'b00, 2'b00, 1};
        vt[12] = '{2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0};

        rst_n = 1'b0;
        clear_inputs();
        #3;
        chk("reset_grant", 64'(grant_o), 64'(0));
        chk("reset_busy", 64'(busy_o), 64'(0));
        chk("reset_s_cyc", 64'(s_cyc_o), 64'(0));
        chk("reset_tie_cti_bte", 64'({s_cti_o, s_bte_o}), 64'(0));
        do_reset();

        // Vector table: rotation, idle gap, error/retry routing.
        for (int i = 0; i < 13; i++) begin
            m_cyc = vt[i].cyc; m_stb = vt[i].stb;
            s_ack = vt[i].ack; s_err = vt[i].err; s_rty = vt[i].rty;
            #3;
            chk($sformatf("vec%0d_grant", i), 64'(grant_o), 64'(vt[i].e_grant));
            chk($sformatf("vec%0d_s_cyc", i), 64'(s_cyc_o), 64'(vt[i].e_scyc));
            chk($sformatf("vec%0d_m_ack", i), 64'(m_ack_o), 64'(vt[i].e_ack));
            chk($sformatf("vec%0d_m_err", i), 64'(m_err_o), 64'(vt[i].e_err));
            chk($sformatf("vec%0d_m_rty", i), 64'(m_rty_o), 64'(vt[i].e_rty));
            chk($sformatf("vec%0d_busy", i), 64'(busy_o), 64'(vt[i].e_busy));
            $display("vec %0d cyc=%b grant=%b s_cyc=%b ack=%b err=%b rty=%b",
                     i, m_cyc, grant_o, s_cyc_o, m_ack_o, m_err_o, m_rty_o);
            next_cyc();
        end
        clear_inputs();

        // Single read from m0: one-cycle arbitration latency, combinational ack.
        do_reset();
        m_cyc = 2'b01; m_stb = 2'b01; m_adr[AW-1:0] = 32'h0000_1000;
        #3 chk("rd_latency_t0", 64'(s_cyc_o), 64'(0));
        next_cyc();
        #3 chk("rd_s_cyc_t1", 64'(s_cyc_o), 64'(1));
        chk("rd_s_adr_t1", 64'(s_adr_o), 64'(32'h0000_1000));
        next_cyc();
        next_cyc();
        s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
        #3 chk("rd_m_ack_t3", 64'(m_ack_o), 64'(2'b01));
        chk("rd_m_dat_t3", 64'(m_dat_o), 64'(32'hDEAD_BEEF));
        $display("read m0 data=%h ack=%b", m_dat_o, m_ack_o);
        next_cyc();
        clear_inputs();
        next_cyc();

        // m1 keeps the port over three beats while m0 waits.
        m_cyc = 2'b10; m_stb = 2'b10;
        next_cyc();
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int b = 0; b < 3; b++) begin
            s_ack = 1'b0;
            #3 chk($sformatf("mb%0d_wait_grant", b), 64'(grant_o), 64'(2'b10));
            next_cyc();
            s_ack = 1'b1;
            #3 chk($sformatf("mb%0d_ack", b), 64'(m_ack_o), 64'(2'b10));
            chk($sformatf("mb%0d_grant", b), 64'(grant_o), 64'(2'b10));
            $display("beat %0d m1 grant=%b ack=%b", b, grant_o, m_ack_o);
            next_cyc();
        end
        s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01;
        #3 chk("mb_drop_s_cyc", 64'(s_cyc_o), 64'(0));
        next_cyc();
        #3 chk("mb_idle_gap", 64'(grant_o), 64'(2'b00));
        next_cyc();
        #3 chk("mb_m0_granted", 64'(grant_o), 64'(2'b01));
        clear_inputs();
        next_cyc();
        next_cyc();

        // Watchdog: slave silent, error pulse 17 cycles after the first strobe.
        m_cyc = 2'b01; m_stb = 2'b01;
        next_cyc();
        for (int k = 0; k <= 16; k++) begin
            #3 chk($sformatf("wd%0d_no_err", k), 64'(m_err_o), 64'(0));
            chk($sformatf("wd%0d_s_stb", k), 64'(s_stb_o), 64'(1));
            next_cyc();
        end
        #3 chk("wd_err_pulse", 64'(m_err_o), 64'(2'b01));
        chk("wd_abort_s_cyc", 64'(s_cyc_o), 64'(0));
        chk("wd_abort_busy", 64'(busy_o), 64'(1));
        $display("watchdog abort err=%b s_cyc=%b", m_err_o, s_cyc_o);
        next_cyc();
        s_ack = 1'b1;
        #3 chk("wd_late_ack", 64'(m_ack_o), 64'(0));
        chk("wd_err_once", 64'(m_err_o), 64'(0));
        chk("wd_stays_off", 64'(s_cyc_o), 64'(0));
        clear_inputs();
        next_cyc();
        next_cyc();

        // Asynchronous reset in the middle of a grant.
        m_cyc = 2'b10; m_stb = 2'b10;
        next_cyc();
        #3 chk("ar_granted", 64'(grant_o), 64'(2'b10));
        next_cyc();
        rst_n = 1'b0;
        #2;
        chk("ar_s_cyc", 64'(s_cyc_o), 64'(0));
        chk("ar_grant", 64'(grant_o), 64'(0));
        chk("ar_busy", 64'(busy_o), 64'(0));
        m_cyc = 2'b11; m_stb = 2'b11;
        next_cyc();
        rst_n = 1'b1;
        #3 chk("ar_idle_after", 64'(grant_o), 64'(0));
        next_cyc();
        #3 chk("ar_m0_first", 64'(grant_o), 64'(2'b01));
        $display("async reset then grant=%b", grant_o);
        clear_inputs();
        next_cyc();

        // Randomized traffic against the model.
        do_reset();
        dead = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NM; i++) begin
                if (!m_cyc[i]) m_cyc[i] = ($urandom_range(0, 3) == 0);
                else if ($urandom_range(0, 7) == 0) m_cyc[i] = 1'b0;
                m_stb[i] = m_cyc[i] & 1'($urandom_range(0, 1));
                m_we[i]  = 1'($urandom_range(0, 1));
                m_adr[i*AW +: AW] = $urandom;
                m_dat[i*DW +: DW] = $urandom;
                m_sel[i*SW +: SW] = SW'($urandom);
            end
            s_dat = $urandom;
            s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
            if (dead > 0) begin
                dead--;
            end else if ($urandom_range(0, 63) == 0) begin
                dead = 25;
            end else begin
                case ($urandom_range(0, 9))
                    0, 1, 2: s_ack = 1'b1;
                    3:       s_err = 1'b1;
                    4:       s_rty = 1'b1;
                    default: ;
                endcase
            end
            #3;
            model_check(c);
            model_clock();
            next_cyc();
        end
        $display("random phase done, 3000 cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
